decompress_stream: RTL and testbench
====================================

Name: decompress_stream

Overview:
- Inverse of the accumulator-to-int8 saturating compression used in the calc datapath.
- Accepts packed int8 words from activation/weight buffers and unpacks them lane by lane.
- Emits one sign-extended, fixed-point-aligned SUM_WIDTH value per cycle, in accumulator format, so compressed results can be re-injected into accumulation (residual adds, bias reload).
- Sits between buffer read ports and PE accumulator inputs, with valid/ready on both sides.

Parameters:
- SUM_WIDTH, 20, output accumulator width; must be ≥ 8+FRAC_BITS+1.
- LANES, 4, int8 lanes per input word; power of two, 2..16.
- FRAC_BITS, 8, left shift applied to each byte; matches compression slice [15:8].

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8*LANES  packed int8; lane k = bits [8k+7:8k].
- in_cnt  in  clog2(LANES)+1  valid lanes in word, 1..LANES; lanes 0..in_cnt-1 used.
- in_last  in  1  word is last of tile.
- in_valid  in  1  input handshake.
- in_ready  out  1  input handshake.
- out_data  out  SUM_WIDTH  signed expanded value.
- out_last  out  1  final element of a tile word marked in_last.
- out_valid  out  1  output handshake.
- out_ready  in  1  output handshake.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_data=0, out_last=0.
  - Lane counter=0, holding register=0, state=IDLE.
  - in_ready=1 after reset releases.
- Reset mid-word discards remaining lanes; there is no partial output.
- Expansion: out_data = sign_extend(byte, SUM_WIDTH) << FRAC_BITS; the low FRAC_BITS bits are always 0.
  - Examples with FRAC_BITS=8: 0x7F -> 0x07F00, 0x80 -> 0xF8000 (−32768).
- Round-trip: compressing out_data returns the original byte for all 256 values.
- States:
  - IDLE: out_valid=0, in_ready=1. On in_valid, latch the word, in_cnt and in_last, set lane=0, go to EMIT.
  - EMIT: out_valid=1, out_data = expanded lane[lane]. On out_ready, lane increments.
    - When the lane at in_cnt−1 is accepted with no new word accepted that cycle, go to IDLE.
- Latency: one cycle from the in handshake to the first out_valid (registered output).
- Throughput: one element per cycle, with no bubble between words.
  - in_ready = (state==IDLE) || (lane==cnt−1 && out_ready).
  - A word accepted in the same cycle as the final lane's out handshake loads directly; EMIT continues with lane=0.
- out_last=1 only on lane cnt−1 of a word latched with in_last=1.
- Output stability: out_data and out_last hold stable while out_valid && !out_ready.
- in_cnt=0 or in_cnt>LANES is illegal; the design treats it as LANES. The assertion fires in simulation only.
- in_data is ignored when in_valid=0.

Optional Feature:
- Macro: DECOMPRESS_ZERO_POINT_EN.
- Defined:
  - Extra port zero_point, in, 8, signed; sampled with each in handshake and held per word.
  - out_data = sign_extend(byte − zero_point, 9 bits) << FRAC_BITS.
  - The 9-bit difference never overflows (range −255..255).
- Undefined: the port is absent and the zero point is implicitly 0.

Decomposition:
- Shared calc package holds:
  - Constants SUM_WIDTH_DEF=20, FRAC_BITS_DEF=8, LANES_DEF=4.
  - The state enum {IDLE, EMIT}.
  - A function expand_int8(byte, zp) returning SUM_WIDTH.
- One natural sub-module, expand_lane: the combinational byte -> accumulator expansion, i.e. the exact mirror of compress_utility.
  - It is instantiated once on the muxed lane, not per lane.
- The top level holds the FSM, lane counter and holding registers.

Test Plan:
- Reset release, then word 0x80_7F_01_FF, cnt=4, out_ready=1 -> outputs 0xFFF00, 0x00100, 0x07F00, 0xF8000 on consecutive cycles, first one cycle after the handshake; out_last=0.
- Back-to-back words, in_valid held high, out_ready=1 -> 8 outputs in 8 consecutive cycles, no bubble; in_ready pulses on the final lane of word 1.
- Word with cnt=2 and in_last=1 -> exactly 2 outputs; the second has out_last=1, then IDLE with in_ready=1.
- out_ready toggled randomly (50%) -> out_data stable while stalled; ordering is preserved; no lane is lost or duplicated against the scoreboard.
- All 256 byte values expanded, then passed through compress_utility -> each result equals its input byte.
- rst_n asserted mid-word at lane 2 -> out_valid drops immediately (async); after release, the next word emits from lane 0.
- With DECOMPRESS_ZERO_POINT_EN: byte 0x80, zero_point=0x7F -> out_data = −255<<8 = 0xF0100.

Source files
------------

// File: rtl/decompress_stream_pkg.sv
// -----------------------------------------------------------------------------
// decompress_stream_pkg
// Shared calc-datapath definitions for the int8 -> accumulator decompressor.
//   SUM_WIDTH_DEF / FRAC_BITS_DEF / LANES_DEF : default widths and lane count
//   state_t                                   : decompressor FSM states
//   expand_int8(b, zp)                        : byte -> accumulator expansion
//                                               at the default widths
// -----------------------------------------------------------------------------
package decompress_stream_pkg;

    localparam int SUM_WIDTH_DEF = 20;
    localparam int FRAC_BITS_DEF = 8;
    localparam int LANES_DEF     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Inverse of the [15:8] saturating slice: the difference is taken at
    // 9 bits so byte - zp (range -255..255) can never wrap.
    function automatic logic signed [SUM_WIDTH_DEF-1:0] expand_int8(
        input logic signed [7:0] b,
        input logic signed [7:0] zp
    );
        logic signed [8:0]               diff;
        logic signed [SUM_WIDTH_DEF-1:0] ext;
        diff = {b[7], b} - {zp[7], zp};
        ext  = {{(SUM_WIDTH_DEF-9){diff[8]}}, diff};
        return ext << FRAC_BITS_DEF;
    endfunction

endpackage

// File: rtl/decompress_stream_expand_lane.sv
// -----------------------------------------------------------------------------
// expand_lane
// Combinational byte -> accumulator expansion, the exact mirror of the
// compression slice. Instantiated once on the currently selected lane.
//   lane_byte  : signed int8 input
//   zero_point : signed int8 zero point (tied to 0 when the feature is off)
//   expanded   : sign_extend(lane_byte - zero_point) << FRAC_BITS
// -----------------------------------------------------------------------------
module expand_lane
    import decompress_stream_pkg::*;
#(
    parameter int SUM_WIDTH = SUM_WIDTH_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic signed [7:0]           lane_byte,
    input  logic signed [7:0]           zero_point,
    output logic signed [SUM_WIDTH-1:0] expanded
);

    function automatic logic signed [SUM_WIDTH-1:0] expand(
        input logic signed [7:0] b,
        input logic signed [7:0] zp
    );
        logic signed [8:0]           diff;
        logic signed [SUM_WIDTH-1:0] ext;
        diff = {b[7], b} - {zp[7], zp};
        ext  = {{(SUM_WIDTH-9){diff[8]}}, diff};
        return ext << FRAC_BITS;
    endfunction

    assign expanded = expand(lane_byte, zero_point);

endmodule

// File: rtl/decompress_stream.sv
// -----------------------------------------------------------------------------
// decompress_stream
// Unpacks packed int8 words lane by lane and emits one sign-extended,
// fixed-point-aligned accumulator value per cycle.
// Optional feature macro: DECOMPRESS_ZERO_POINT_EN (adds zero_point input).
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_data/in_cnt/in_last: packed word, valid lane count (1..LANES), tile end
//   in_valid/in_ready     : input handshake
//   zero_point            : per-word signed zero point (feature only)
//   out_data/out_last     : expanded value, last element of an in_last word
//   out_valid/out_ready   : output handshake
// -----------------------------------------------------------------------------
module decompress_stream
    import decompress_stream_pkg::*;
#(
    parameter int SUM_WIDTH = SUM_WIDTH_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [8*LANES-1:0]          in_data,
    input  logic [$clog2(LANES):0]      in_cnt,
    input  logic                        in_last,
    input  logic                        in_valid,
    output logic                        in_ready,
`ifdef DECOMPRESS_ZERO_POINT_EN
    input  logic signed [7:0]           zero_point,
`endif
    output logic signed [SUM_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int LW = $clog2(LANES);
    localparam int CW = LW + 1;

    state_t                   state;
    logic [LANES-1:0][7:0]    word_p0;
    logic [LW-1:0]            lane_p0;
    logic [LW-1:0]            last_idx_p0;
    logic                     last_p0;
    logic [LW-1:0]            nxt_lane;
    logic [LW-1:0]            in_last_idx;
    logic                     cnt_bad;
    logic                     at_last;
    logic                     in_fire;
    logic                     out_fire;
    logic signed [7:0]        byte_sel;
    logic signed [7:0]        zp_sel;
    logic signed [SUM_WIDTH-1:0] expanded;

`ifdef DECOMPRESS_ZERO_POINT_EN
    logic signed [7:0]        zp_p0;
`endif

    // Illegal counts (0 or above LANES) fall back to a full word.
    assign cnt_bad     = (in_cnt == '0) || (in_cnt > CW'(LANES));
    assign in_last_idx = cnt_bad ? LW'(LANES - 1) : LW'(in_cnt - CW'(1));

    assign at_last  = (lane_p0 == last_idx_p0);
    assign in_ready = (state == IDLE) || (at_last && out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign nxt_lane = lane_p0 + LW'(1);

    // The expander sees the byte that will be presented next cycle: lane 0 of
    // an incoming word, otherwise the following lane of the held word.
    assign byte_sel = in_fire ? in_data[7:0] : word_p0[nxt_lane];
`ifdef DECOMPRESS_ZERO_POINT_EN
    assign zp_sel   = in_fire ? zero_point : zp_p0;
`else
    assign zp_sel   = 8'sd0;
`endif

    expand_lane #(
        .SUM_WIDTH (SUM_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_expand (
        .lane_byte  (byte_sel),
        .zero_point (zp_sel),
        .expanded   (expanded)
    );

    // Stage p0: holding registers, lane counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            word_p0     <= '0;
            lane_p0     <= '0;
            last_idx_p0 <= '0;
            last_p0     <= 1'b0;
`ifdef DECOMPRESS_ZERO_POINT_EN
            zp_p0       <= '0;
`endif
        end else if (in_fire) begin
            state       <= EMIT;
            out_valid   <= 1'b1;
            word_p0     <= in_data;
            lane_p0     <= '0;
            last_idx_p0 <= in_last_idx;
            last_p0     <= in_last;
`ifdef DECOMPRESS_ZERO_POINT_EN
            zp_p0       <= zero_point;
`endif
            out_data    <= expanded;
            out_last    <= in_last && (in_last_idx == '0);
        end else if (out_fire) begin
            if (at_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                lane_p0   <= nxt_lane;
                out_data  <= expanded;
                out_last  <= last_p0 && (nxt_lane == last_idx_p0);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && in_fire) begin
            assert (!cnt_bad);
        end
    end
`endif

endmodule

// File: tb/tb_decompress_stream.sv
`timescale 1ns/1ps
module tb_decompress_stream;

    localparam int SW    = 20;
    localparam int LANES = 4;
    localparam int FRAC  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   in_data = '0;
    logic [2:0]    in_cnt = 3'd4;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef DECOMPRESS_ZERO_POINT_EN
    logic [7:0]    zp_drv = 8'h00;
`endif

    int   tests = 0;
    int   fails = 0;
    logic rand_rdy = 1'b0;

    typedef struct {
        logic [7:0]    b;
        logic [7:0]    zp;
        logic [SW-1:0] d;
        logic          l;
    } exp_t;
    exp_t exp_q[$];

    logic [SW-1:0] t1_exp [4] = '{20'hFFF00, 20'h00100, 20'h07F00, 20'hF8000};

    always #5 clk = ~clk;

    decompress_stream #(
        .SUM_WIDTH (SW),
        .LANES     (LANES),
        .FRAC_BITS (FRAC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_cnt     (in_cnt),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
`ifdef DECOMPRESS_ZERO_POINT_EN
        .zero_point (zp_drv),
`endif
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Reference: plain integer arithmetic on the signed byte value.
    function automatic logic [SW-1:0] model_expand(input logic [7:0] b, input logic [7:0] zp);
        int v;
        v = (int'($signed(b)) - int'($signed(zp))) * (1 << FRAC);
        return v[SW-1:0];
    endfunction

    // Accumulator -> int8 compression: arithmetic shift then saturate.
    function automatic logic [7:0] compress(input logic [SW-1:0] x);
        int v;
        v = int'($signed(x)) >>> FRAC;
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return v[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard / compare process, sampled on the falling edge.
    logic          stall_prev = 1'b0;
    logic [SW-1:0] stall_d;
    logic          stall_l;
    always @(negedge clk) begin : mon
        exp_t e;
        exp_t n;
        int   eff;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (out_valid) begin
                if (stall_prev) begin
                    check("stall_data", out_data, stall_d);
                    check("stall_last", out_last, stall_l);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_unexpected: got output %0h, expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", out_data, e.d);
                        check("sb_last", out_last, e.l);
                        if (e.zp == 8'h00) check("roundtrip", compress(out_data), e.b);
                    end
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    stall_d    = out_data;
                    stall_l    = out_last;
                end
            end else begin
                stall_prev = 1'b0;
            end
            if (in_valid && in_ready) begin
                eff = (in_cnt == 0 || in_cnt > LANES) ? LANES : int'(in_cnt);
                for (int k = 0; k < eff; k++) begin
                    n.b  = in_data[8*k +: 8];
`ifdef DECOMPRESS_ZERO_POINT_EN
                    n.zp = zp_drv;
`else
                    n.zp = 8'h00;
`endif
                    n.d  = model_expand(n.b, n.zp);
                    n.l  = in_last && (k == eff - 1);
                    exp_q.push_back(n);
                end
            end
        end
    end

    // Random backpressure driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Call after a rising edge; returns #1 after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic [2:0] c, input logic l);
        logic fire;
        in_data  = d;
        in_cnt   = c;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            fire = in_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        tests++;
        fails++;
        $display("FAIL send_timeout: word %0h not accepted, expected acceptance within 200 cycles", d);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", in_ready, 1);

        // Single word, literal expectations, one-cycle latency
        out_ready = 1'b1;
        send_word(32'h807F01FF, 3'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid", out_valid, 1);
            check("t1_data", out_data, t1_exp[i]);
            check("t1_last", out_last, 0);
        end
        @(negedge clk);
        check("t1_idle_valid", out_valid, 0);
        check("t1_idle_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Back-to-back words with in_valid held high
        in_data  = 32'h04030201;
        in_cnt   = 3'd4;
        in_last  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_data = 32'hFCFDFEFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_nobubble", out_valid, 1);
            check("t2_in_ready", in_ready, (i == 3 || i == 7) ? 1 : 0);
            @(posedge clk);
            #1;
            if (i == 3) in_valid = 1'b0;
        end
        wait_drain("t2_drain");

        // Short word with in_last
        send_word(32'hAABB857A, 3'd2, 1'b1);
        @(negedge clk);
        check("t3_data0", out_data, 20'h07A00);
        check("t3_last0", out_last, 0);
        @(negedge clk);
        check("t3_data1", out_data, 20'hF8500);
        check("t3_last1", out_last, 1);
        @(negedge clk);
        check("t3_idle_valid", out_valid, 0);
        check("t3_idle_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Random backpressure
        rand_rdy = 1'b1;
        send_word(32'h12345678, 3'd4, 1'b0);
        send_word(32'h9ABCDEF0, 3'd3, 1'b1);
        send_word(32'h00000081, 3'd1, 1'b0);
        send_word(32'h7F80FF00, 3'd4, 1'b1);
        send_word(32'h0000C33C, 3'd2, 1'b0);
        send_word(32'hA5A55A5A, 3'd4, 1'b1);
        wait_drain("t4_drain");
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // All 256 byte values, round-trip checked by the scoreboard
        for (int wd = 0; wd < 64; wd++) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4 * wd + k);
            send_word(w, 3'd4, wd == 63);
        end
        wait_drain("t5_drain");

        // Reset in the middle of a word
        send_word(32'h44332211, 3'd4, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t6_lane2_data", out_data, 20'h03300);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'h88776655, 3'd4, 1'b1);
        @(negedge clk);
        check("t6_restart_data", out_data, 20'h05500);
        wait_drain("t6_drain");

`ifdef DECOMPRESS_ZERO_POINT_EN
        zp_drv = 8'h7F;
        send_word(32'h00000080, 3'd1, 1'b1);
        @(negedge clk);
        check("t7_zp_data", out_data, 20'hF0100);
        check("t7_zp_last", out_last, 1);
        wait_drain("t7_drain");
        zp_drv = 8'h00;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
